// File: rtl/bit_sync_filter_pkg.sv
// bit_sync_pkg: shared defaults, edge encoding and counter-width helper for bit_sync_filter.
package bit_sync_pkg;
    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_FILT_CNT   = 3;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_e;

    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/bit_sync_filter_if.sv
// bit_sync_filter_if: level inputs and filtered level/pulse outputs of bit_sync_filter.
interface bit_sync_filter_if
    import bit_sync_pkg::*;
#(
    parameter int Width = DEF_WIDTH
) ();
    logic [Width-1:0] Async_data;
    logic [Width-1:0] sync_data;
    logic [Width-1:0] rise_pulse;
    logic [Width-1:0] fall_pulse;

    modport master (output Async_data, input sync_data, rise_pulse, fall_pulse);
    modport slave  (input Async_data, output sync_data, rise_pulse, fall_pulse);
endinterface

// File: rtl/bit_sync_filter_channel.sv
// deglitch_channel: one-bit synchronizer chain followed by a stability filter with edge pulses.
module deglitch_channel
    import bit_sync_pkg::*;
#(
    parameter int   NUM_Stages = DEF_NUM_STAGES,
    parameter int   FILT_CNT   = DEF_FILT_CNT,
    parameter logic INIT       = 1'b0
) (
    input  logic CLK,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);
    localparam int CW = clog2(FILT_CNT + 1);

    logic [NUM_Stages-1:0] chain;
    logic [CW-1:0]         cnt;
    logic                  s;
    edge_e                 kind;

    assign s = chain[NUM_Stages-1];

    // The output flips on the FILT_CNT-th consecutive disagreeing sample.
    always_comb
        kind = (s == sync_out || cnt != CW'(FILT_CNT - 1)) ? EDGE_NONE :
               s ? EDGE_RISE : EDGE_FALL;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            chain    <= {NUM_Stages{INIT}};
            cnt      <= '0;
            sync_out <= INIT;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            chain    <= {chain[NUM_Stages-2:0], async_in};
            cnt      <= (s == sync_out || kind != EDGE_NONE) ? '0 : cnt + CW'(1);
            sync_out <= (kind == EDGE_NONE) ? sync_out : s;
            rise     <= kind == EDGE_RISE;
            fall     <= kind == EDGE_FALL;
        end
    end
endmodule

// File: rtl/bit_sync_filter.sv
// bit_sync_filter: Width independent synchronize-and-deglitch channels with rise/fall pulses.
module bit_sync_filter
    import bit_sync_pkg::*;
#(
    parameter int             NUM_Stages = DEF_NUM_STAGES,
    parameter int             Width      = DEF_WIDTH,
    parameter int             FILT_CNT   = DEF_FILT_CNT,
    parameter logic [Width-1:0] INIT     = '0
) (
    input logic               CLK,
    input logic               Reset,
    bit_sync_filter_if.slave  bus
);
    logic [Width-1:0] sync_v;
    logic [Width-1:0] rise_v;
    logic [Width-1:0] fall_v;

    for (genvar i = 0; i < Width; i++) begin : g_ch
        deglitch_channel #(
            .NUM_Stages (NUM_Stages),
            .FILT_CNT   (FILT_CNT),
            .INIT       (INIT[i])
        ) u_ch (
            .CLK      (CLK),
            .Reset    (Reset),
            .async_in (bus.Async_data[i]),
            .sync_out (sync_v[i]),
            .rise     (rise_v[i]),
            .fall     (fall_v[i])
        );
    end

    assign bus.sync_data  = sync_v;
    assign bus.rise_pulse = rise_v;
    assign bus.fall_pulse = fall_v;
endmodule

// File: tb/tb_bit_sync_filter.sv
// tb_bit_sync_filter: three bit_sync_filter configurations checked against a sliding-window reference.
module tb_bit_sync_filter;
    logic       CLK_tb = 1'b0;
    logic       rst_tb = 1'b1;
    logic [3:0] din    = 4'h0;
    int         n_vec  = 0;
    int         n_err  = 0;

    always #5 CLK_tb = ~CLK_tb;

    bit_sync_filter_if #(.Width(4)) if_a ();
    bit_sync_filter_if #(.Width(4)) if_b ();
    bit_sync_filter_if #(.Width(4)) if_c ();

    assign if_a.Async_data = din;
    assign if_b.Async_data = din;
    assign if_c.Async_data = din;

    bit_sync_filter #(.NUM_Stages(3), .Width(4), .FILT_CNT(3), .INIT(4'h0))
        dut_a (.CLK(CLK_tb), .Reset(rst_tb), .bus(if_a));
    bit_sync_filter #(.NUM_Stages(2), .Width(4), .FILT_CNT(1), .INIT(4'h0))
        dut_b (.CLK(CLK_tb), .Reset(rst_tb), .bus(if_b));
    bit_sync_filter #(.NUM_Stages(3), .Width(4), .FILT_CNT(3), .INIT(4'h8))
        dut_c (.CLK(CLK_tb), .Reset(rst_tb), .bus(if_c));

    logic [3:0] act_s[3], act_r[3], act_f[3];
    assign act_s[0] = if_a.sync_data;  assign act_r[0] = if_a.rise_pulse;  assign act_f[0] = if_a.fall_pulse;
    assign act_s[1] = if_b.sync_data;  assign act_r[1] = if_b.rise_pulse;  assign act_f[1] = if_b.fall_pulse;
    assign act_s[2] = if_c.sync_data;  assign act_r[2] = if_c.rise_pulse;  assign act_f[2] = if_c.fall_pulse;

    // Reference: s is the input delayed by the chain depth; an output bit flips
    // once the last FILT_CNT samples since reset all disagree with it.
    int         ns[3]  = '{3, 2, 3};
    int         fc[3]  = '{3, 1, 3};
    logic [3:0] ini[3] = '{4'h0, 4'h0, 4'h8};
    logic [3:0] dly[3][8];
    logic [3:0] win[3][3];
    int         wn[3];
    logic [3:0] exp_s[3], exp_r[3], exp_f[3];

    task automatic model_step();
        logic [3:0] s;
        logic       all_diff;
        for (int k = 0; k < 3; k++) begin
            if (rst_tb) begin
                for (int j = 0; j < 8; j++) dly[k][j] = ini[k];
                wn[k]    = 0;
                exp_s[k] = ini[k];
                exp_r[k] = 4'h0;
                exp_f[k] = 4'h0;
            end else begin
                s = dly[k][ns[k]-1];
                for (int j = 7; j > 0; j--) dly[k][j] = dly[k][j-1];
                dly[k][0] = din;
                for (int j = 2; j > 0; j--) win[k][j] = win[k][j-1];
                win[k][0] = s;
                if (wn[k] < fc[k]) wn[k]++;
                exp_r[k] = 4'h0;
                exp_f[k] = 4'h0;
                if (wn[k] == fc[k])
                    for (int b = 0; b < 4; b++) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < fc[k]; j++)
                            if (win[k][j][b] == exp_s[k][b]) all_diff = 1'b0;
                        if (all_diff) begin
                            exp_s[k][b] = s[b];
                            exp_r[k][b] = s[b];
                            exp_f[k][b] = ~s[b];
                        end
                    end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK_tb);
        @(negedge CLK_tb);
    endtask

    task automatic test_reset();
        rst_tb = 1'b1;
        din    = 4'h5;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if ({act_s[k], act_r[k], act_f[k]} !== {exp_s[k], exp_r[k], exp_f[k]}) begin
                n_err++;
                $display("FAIL reset dut%0d: got s=%h r=%h f=%h, expected s=%h r=%h f=%h",
                         k, act_s[k], act_r[k], act_f[k], exp_s[k], exp_r[k], exp_f[k]);
            end
        end
        n_vec++;
        if ({act_s[2], act_r[2], act_f[2]} !== {4'h8, 4'h0, 4'h0}) begin
            n_err++;
            $display("FAIL reset_init dut2: got s=%h r=%h f=%h, expected s=8 r=0 f=0",
                     act_s[2], act_r[2], act_f[2]);
        end
    endtask

    task automatic test_power_up();
        rst_tb = 1'b1;
        din    = 4'h0;
        tick();
        rst_tb = 1'b0;
        din    = 4'hF;
        for (int e = 1; e <= 10; e++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_s[k], act_r[k], act_f[k]} !== {exp_s[k], exp_r[k], exp_f[k]}) begin
                    n_err++;
                    $display("FAIL power_up dut%0d edge %0d: got s=%h r=%h f=%h, expected s=%h r=%h f=%h",
                             k, e, act_s[k], act_r[k], act_f[k], exp_s[k], exp_r[k], exp_f[k]);
                end
            end
            if (e == 5 || e == 6 || e == 7) begin
                n_vec++;
                if ({act_s[0], act_r[0], act_f[0]} !== (e == 5 ? 12'h000 : e == 6 ? 12'hFF0 : 12'hF00)) begin
                    n_err++;
                    $display("FAIL power_up_latency dut0 edge %0d: got s=%h r=%h f=%h", e, act_s[0], act_r[0], act_f[0]);
                end
            end
            if (e == 2 || e == 3) begin
                n_vec++;
                if ({act_s[1], act_r[1]} !== (e == 2 ? 8'h00 : 8'hFF)) begin
                    n_err++;
                    $display("FAIL power_up_latency dut1 edge %0d: got s=%h r=%h", e, act_s[1], act_r[1]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 26; c++) begin
            din = (c >= 12 && c < 14) ? 4'h1 : 4'h0;
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_s[k], act_r[k], act_f[k]} !== {exp_s[k], exp_r[k], exp_f[k]}) begin
                    n_err++;
                    $display("FAIL glitch dut%0d cycle %0d: got s=%h r=%h f=%h, expected s=%h r=%h f=%h",
                             k, c, act_s[k], act_r[k], act_f[k], exp_s[k], exp_r[k], exp_f[k]);
                end
            end
            if (c >= 12) begin
                n_vec++;
                if ({act_s[0], act_r[0], act_f[0]} !== 12'h000) begin
                    n_err++;
                    $display("FAIL glitch_reject dut0 cycle %0d: got s=%h r=%h f=%h, expected all 0",
                             c, act_s[0], act_r[0], act_f[0]);
                end
            end
        end
    endtask

    task automatic test_short_pulse();
        int hi = 0, nr = 0, nf = 0;
        for (int c = 0; c < 30; c++) begin
            din = (c >= 12 && c < 15) ? 4'h1 : 4'h0;
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_s[k], act_r[k], act_f[k]} !== {exp_s[k], exp_r[k], exp_f[k]}) begin
                    n_err++;
                    $display("FAIL short_pulse dut%0d cycle %0d: got s=%h r=%h f=%h, expected s=%h r=%h f=%h",
                             k, c, act_s[k], act_r[k], act_f[k], exp_s[k], exp_r[k], exp_f[k]);
                end
            end
            if (c >= 12) begin
                hi += int'(act_s[0] == 4'h1);
                nr += int'(act_r[0] == 4'h1);
                nf += int'(act_f[0] == 4'h1);
            end
        end
        n_vec++;
        if (hi != 3 || nr != 1 || nf != 1) begin
            n_err++;
            $display("FAIL short_pulse_counts dut0: got high=%0d rise=%0d fall=%0d, expected 3 1 1", hi, nr, nf);
        end
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < 30; c++) begin
            din = (c < 12) ? 4'h4 : 4'h2;
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_s[k], act_r[k], act_f[k]} !== {exp_s[k], exp_r[k], exp_f[k]}) begin
                    n_err++;
                    $display("FAIL simultaneous dut%0d cycle %0d: got s=%h r=%h f=%h, expected s=%h r=%h f=%h",
                             k, c, act_s[k], act_r[k], act_f[k], exp_s[k], exp_r[k], exp_f[k]);
                end
            end
            if (c == 16 || c == 17) begin
                n_vec++;
                if ({act_s[0], act_r[0], act_f[0]} !== (c == 16 ? 12'h400 : 12'h224)) begin
                    n_err++;
                    $display("FAIL simultaneous_edge dut0 cycle %0d: got s=%h r=%h f=%h", c, act_s[0], act_r[0], act_f[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 30; c++) begin
            din    = (c >= 12 && c < 17) ? 4'h0 : 4'h8;
            rst_tb = (c == 17);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_s[k], act_r[k], act_f[k]} !== {exp_s[k], exp_r[k], exp_f[k]}) begin
                    n_err++;
                    $display("FAIL reset_mid dut%0d cycle %0d: got s=%h r=%h f=%h, expected s=%h r=%h f=%h",
                             k, c, act_s[k], act_r[k], act_f[k], exp_s[k], exp_r[k], exp_f[k]);
                end
            end
            if (c >= 17) begin
                n_vec++;
                if ({act_s[2], act_r[2], act_f[2]} !== 12'h800) begin
                    n_err++;
                    $display("FAIL reset_mid_discard dut2 cycle %0d: got s=%h r=%h f=%h, expected s=8 r=0 f=0",
                             c, act_s[2], act_r[2], act_f[2]);
                end
            end
            if (c == 22 || c == 23) begin
                n_vec++;
                if ({act_s[0], act_r[0]} !== (c == 22 ? 8'h00 : 8'h88)) begin
                    n_err++;
                    $display("FAIL reset_mid_resume dut0 cycle %0d: got s=%h r=%h", c, act_s[0], act_r[0]);
                end
            end
        end
        rst_tb = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                din  = 4'($urandom);
                hold = $urandom_range(1, 6);
            end
            hold--;
            rst_tb = ($urandom_range(0, 99) == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({act_s[k], act_r[k], act_f[k]} !== {exp_s[k], exp_r[k], exp_f[k]} ||
                    (act_r[k] & act_f[k]) !== 4'h0) begin
                    n_err++;
                    $display("FAIL random dut%0d cycle %0d: got s=%h r=%h f=%h, expected s=%h r=%h f=%h",
                             k, c, act_s[k], act_r[k], act_f[k], exp_s[k], exp_r[k], exp_f[k]);
                end
            end
        end
        rst_tb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_glitch();
        test_short_pulse();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
